// File: rtl/inst_mem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: memory geometry,
// loader FSM states and stream framing constants.
package inst_mem_loader_pkg;

  localparam int DATA_WIDTH          = 32;
  localparam int INST_MEM_DEPTH      = 16;
  localparam int INST_MEM_ADDR_WIDTH = $clog2(INST_MEM_DEPTH);

  localparam int LOADER_BYTES_PER_WORD = DATA_WIDTH / 8;
  localparam int LOADER_HDR_BYTES      = 4;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    LOAD,
    FINISH,
    DONE,
    ERROR
  } loader_state_t;

endpackage

// File: rtl/inst_mem_loader_byte_packer.sv
// Little-endian 8->WIDTH assembler. word/word_valid show the completed word in the
// same cycle its last byte is strobed, so the consumer can register it on that edge.
module byte_packer
  import inst_mem_loader_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_strobe,
  input  logic [7:0]       in_byte,
  output logic [WIDTH-1:0] word,
  output logic             word_valid
);

  localparam int BYTES = WIDTH / 8;
  localparam int LW    = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [WIDTH-9:0] shreg;
  logic [LW-1:0]    lane;

  // Newest byte lands on top, so after BYTES strobes byte 0 sits in bits [7:0].
  assign word       = {in_byte, shreg};
  assign word_valid = in_strobe && (lane == LW'(BYTES - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      shreg <= '0;
      lane  <= '0;
    end else if (in_strobe) begin
      shreg <= word[WIDTH-1:8];
      lane  <= word_valid ? '0 : lane + LW'(1);
    end
  end

endmodule

// File: rtl/inst_mem_loader.sv
// Byte-stream program loader: decodes a word-count header, packs the payload into
// instruction words and writes them to inst_mem while holding the core.
module inst_mem_loader
  import inst_mem_loader_pkg::*;
#(
  parameter bit BOOT_HOLD = 1'b0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           in_valid,
  input  logic [7:0]                     in_data,
  output logic                           in_ready,
  output logic                           wr_en,
  output logic [INST_MEM_ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0]          wr_data,
  output logic                           cpu_hold,
  output logic                           load_done,
  output logic                           load_error
);

  loader_state_t                  state;
  logic [31:0]                    cnt;
  logic [INST_MEM_ADDR_WIDTH-1:0] word_idx;
  logic                           xfer;
  logic [DATA_WIDTH-1:0]          pk_word;
  logic                           pk_valid;
  logic [31:0]                    hdr_n;

  assign xfer  = in_valid & in_ready;
  assign hdr_n = 32'(pk_word);

  // One packer serves both the header and the payload; start drops any partial word.
  byte_packer #(.WIDTH(DATA_WIDTH)) u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (start),
    .in_strobe  (xfer),
    .in_byte    (in_data),
    .word       (pk_word),
    .word_valid (pk_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      cpu_hold   <= BOOT_HOLD;
      load_done  <= 1'b0;
      load_error <= 1'b0;
      cnt        <= '0;
      word_idx   <= '0;
    end else if (start) begin
      state      <= HEADER;
      in_ready   <= 1'b1;
      cpu_hold   <= 1'b1;
      wr_en      <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
      cnt        <= '0;
      word_idx   <= '0;
    end else begin
      wr_en <= 1'b0;
      unique case (state)
        HEADER: begin
          if (pk_valid) begin
            cnt <= hdr_n;
            if (hdr_n == 32'd0) begin
              state     <= DONE;
              in_ready  <= 1'b0;
              cpu_hold  <= 1'b0;
              load_done <= 1'b1;
            end else if (hdr_n > 32'(INST_MEM_DEPTH)) begin
              state      <= ERROR;
              in_ready   <= 1'b0;
              load_error <= 1'b1;
            end else begin
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          if (pk_valid) begin
            wr_en    <= 1'b1;
            wr_addr  <= word_idx;
            wr_data  <= pk_word;
            word_idx <= word_idx + INST_MEM_ADDR_WIDTH'(1);
            // Stop taking bytes once the last word is in; FINISH covers its write cycle.
            if (32'(word_idx) == cnt - 32'd1) begin
              state    <= FINISH;
              in_ready <= 1'b0;
            end
          end
        end
        FINISH: begin
          state     <= DONE;
          cpu_hold  <= 1'b0;
          load_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Self-checking bench for inst_mem_loader: table of load scenarios with random
// payloads and gaps, checked against a stream-decoding reference model.
module tb_inst_mem_loader;
  import inst_mem_loader_pkg::*;

  typedef logic [7:0] byte_q_t[$];

  typedef struct packed {
    logic [INST_MEM_ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]          data;
  } wr_t;

  typedef struct {
    string       name;
    int unsigned n_words;
    int          gap_pct;
    bit          fixed_img;
    bit          exp_done;
    bit          exp_error;
    bit          exp_hold;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic [7:0] in_data = 8'hFF;

  logic                           in_ready, wr_en, cpu_hold, load_done, load_error;
  logic [INST_MEM_ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0]          wr_data;

  logic                           h_in_ready, h_wr_en, h_cpu_hold, h_load_done, h_load_error;
  logic [INST_MEM_ADDR_WIDTH-1:0] h_wr_addr;
  logic [DATA_WIDTH-1:0]          h_wr_data;

  int check_count = 0;
  int pass_count  = 0;

  wr_t got_q[$];
  wr_t exp_q[$];
  logic [DATA_WIDTH-1:0] mem [INST_MEM_DEPTH];

  always #5 clk = ~clk;

  inst_mem_loader #(.BOOT_HOLD(1'b0)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_error(load_error)
  );

  inst_mem_loader #(.BOOT_HOLD(1'b1)) dut_h (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(h_in_ready), .wr_en(h_wr_en), .wr_addr(h_wr_addr), .wr_data(h_wr_data),
    .cpu_hold(h_cpu_hold), .load_done(h_load_done), .load_error(h_load_error)
  );

  // Acts as the instruction memory: records every write strobe seen mid-cycle.
  always @(negedge clk) begin
    if (wr_en) begin
      got_q.push_back('{addr: wr_addr, data: wr_data});
      mem[wr_addr] = wr_data;
    end
  end

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
  endtask

  // Reference model: decode header count, then emit one write per 4 payload bytes.
  task automatic build_expected(input byte_q_t bytes);
    longint unsigned n;
    exp_q.delete();
    if (bytes.size() < 4) return;
    n = bytes[0] + 256 * bytes[1] + 65536 * bytes[2] + 16777216 * longint'(bytes[3]);
    if (n == 0 || n > INST_MEM_DEPTH) return;
    for (int i = 0; i < int'(n); i++) begin
      longint unsigned w = 0;
      for (int k = 3; k >= 0; k--) w = w * 256 + bytes[4 + 4 * i + k];
      exp_q.push_back('{addr: INST_MEM_ADDR_WIDTH'(i), data: DATA_WIDTH'(w)});
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'hFF;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic apply_stimulus(input byte_q_t bytes, input int gap_pct);
    int idx = 0;
    int guard = 0;
    while (idx < bytes.size() && guard < 4000) begin
      @(negedge clk);
      guard++;
      if (int'($urandom_range(99)) < gap_pct) begin
        in_valid = 1'b0; in_data = 8'hFF;
      end else begin
        in_valid = 1'b1; in_data = bytes[idx];
        if (in_ready) idx++;
      end
    end
    check_output("bytes_accepted", 64'(idx), 64'(bytes.size()));
  endtask

  task automatic push_word(inout byte_q_t q, input logic [31:0] w);
    for (int k = 0; k < 4; k++) q.push_back(w[8*k +: 8]);
  endtask

  task automatic wait_end();
    int waited = 0;
    while (!(load_done || load_error) && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check_output("end_timeout", 64'(!(load_done || load_error)), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic compare_writes(input string tag);
    check_output({tag, "_wr_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check_output({tag, "_wr"}, 64'(got_q[i]), 64'(exp_q[i]));
  endtask

  task automatic run_vector(input vec_t v);
    byte_q_t bytes;
    bytes.delete();
    if (v.fixed_img) begin
      bytes = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
                8'h93, 8'h05, 8'h20, 8'h00};
    end else begin
      push_word(bytes, v.n_words);
      if (!v.exp_error)
        for (int i = 0; i < int'(v.n_words); i++) push_word(bytes, $urandom);
    end
    build_expected(bytes);
    got_q.delete();
    for (int i = 0; i < INST_MEM_DEPTH; i++) mem[i] = '0;

    pulse_start();
    apply_stimulus(bytes, v.gap_pct);
    @(negedge clk);
    in_valid = 1'b0; in_data = 8'hFF;
    if (v.exp_error) begin
      check_output({v.name, "_err_now"}, 64'(load_error), 64'd1);
      check_output({v.name, "_err_rdy"}, 64'(in_ready), 64'd0);
    end else if (v.n_words == 0) begin
      check_output({v.name, "_done_now"}, 64'(load_done), 64'd1);
    end else begin
      check_output({v.name, "_last_wr_en"}, 64'(wr_en), 64'd1);
      check_output({v.name, "_last_wr_addr"}, 64'(wr_addr), 64'(v.n_words - 1));
      check_output({v.name, "_last_rdy"}, 64'(in_ready), 64'd0);
    end
    wait_end();
    check_output({v.name, "_done"}, 64'(load_done), 64'(v.exp_done));
    check_output({v.name, "_error"}, 64'(load_error), 64'(v.exp_error));
    check_output({v.name, "_hold"}, 64'(cpu_hold), 64'(v.exp_hold));
    check_output({v.name, "_rdy"}, 64'(in_ready), 64'd0);
    compare_writes(v.name);
    if (v.fixed_img && got_q.size() == 2) begin
      check_output({v.name, "_w0"}, 64'(got_q[0].data), 64'h00100513);
      check_output({v.name, "_w1"}, 64'(got_q[1].data), 64'h00200593);
    end
    if (v.n_words == INST_MEM_DEPTH && exp_q.size() == INST_MEM_DEPTH)
      for (int i = 0; i < INST_MEM_DEPTH; i++)
        check_output("readback", 64'(mem[i]), 64'(exp_q[i].data));
  endtask

  vec_t vecs[8];

  initial begin
    byte_q_t bytes;
    logic [31:0] w;

    vecs[0] = '{"fixed_b2b",  2, 0,  1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{"fixed_gaps", 2, 50, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{"zero_hdr",   0, 0,  1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{"too_big",    INST_MEM_DEPTH + 1, 0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{"huge_hdr",   32'h8000_0001, 30, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{"one_word",   1, 25, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{"five_words", 5, 30, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{"full_depth", INST_MEM_DEPTH, 20, 1'b0, 1'b1, 1'b0, 1'b0};

    do_reset();
    @(negedge clk);
    check_output("rst_in_ready", 64'(in_ready), 64'd0);
    check_output("rst_wr_en", 64'(wr_en), 64'd0);
    check_output("rst_wr_addr", 64'(wr_addr), 64'd0);
    check_output("rst_wr_data", 64'(wr_data), 64'd0);
    check_output("rst_cpu_hold", 64'(cpu_hold), 64'd0);
    check_output("rst_load_done", 64'(load_done), 64'd0);
    check_output("rst_load_error", 64'(load_error), 64'd0);
    check_output("rsth_cpu_hold", 64'(h_cpu_hold), 64'd1);
    check_output("rsth_in_ready", 64'(h_in_ready), 64'd0);
    check_output("rsth_wr_en", 64'(h_wr_en), 64'd0);
    check_output("rsth_wr_addr", 64'(h_wr_addr), 64'd0);
    check_output("rsth_wr_data", 64'(h_wr_data), 64'd0);
    check_output("rsth_done_err", 64'({h_load_done, h_load_error}), 64'd0);

    foreach (vecs[i]) run_vector(vecs[i]);

    // Restart after 6 of 8 payload bytes: the half word must not leak into the new image.
    got_q.delete();
    bytes.delete();
    push_word(bytes, 32'd2);
    push_word(bytes, 32'hA1B2_C3D4);
    bytes.push_back(8'h55); bytes.push_back(8'h66);
    pulse_start();
    apply_stimulus(bytes, 0);
    @(negedge clk); in_valid = 1'b0;
    w = $urandom;
    bytes.delete();
    push_word(bytes, 32'd1);
    push_word(bytes, w);
    pulse_start();
    apply_stimulus(bytes, 10);
    @(negedge clk); in_valid = 1'b0;
    wait_end();
    check_output("restart_wr_count", 64'(got_q.size()), 64'd2);
    if (got_q.size() == 2)
      check_output("restart_wr", 64'(got_q[1]), 64'({INST_MEM_ADDR_WIDTH'(0), w}));
    check_output("restart_done", 64'(load_done), 64'd1);

    // start coinciding with a word's final byte suppresses that write.
    got_q.delete();
    bytes.delete();
    push_word(bytes, 32'd2);
    bytes.push_back(8'h01); bytes.push_back(8'h02); bytes.push_back(8'h03);
    pulse_start();
    apply_stimulus(bytes, 0);
    @(negedge clk); in_valid = 1'b1; in_data = 8'h04; start = 1'b1;
    @(negedge clk); in_valid = 1'b0; in_data = 8'hFF; start = 1'b0;
    check_output("coinc_wr_en", 64'(wr_en), 64'd0);
    check_output("coinc_in_ready", 64'(in_ready), 64'd1);
    repeat (3) @(negedge clk);
    check_output("coinc_wr_count", 64'(got_q.size()), 64'd0);
    check_output("coinc_done", 64'(load_done), 64'd0);

    // Reset arriving with a word's final byte: reset values, no stray write.
    got_q.delete();
    bytes.delete();
    push_word(bytes, 32'd3);
    push_word(bytes, $urandom);
    bytes.push_back(8'h11); bytes.push_back(8'h22); bytes.push_back(8'h33);
    pulse_start();
    apply_stimulus(bytes, 0);
    @(negedge clk); in_valid = 1'b1; in_data = 8'h44; rst = 1'b1;
    @(negedge clk); in_valid = 1'b0; in_data = 8'hFF;
    check_output("midrst_wr_en", 64'(wr_en), 64'd0);
    check_output("midrst_in_ready", 64'(in_ready), 64'd0);
    check_output("midrst_cpu_hold", 64'(cpu_hold), 64'd0);
    check_output("midrst_wr_addr", 64'(wr_addr), 64'd0);
    check_output("midrst_wr_data", 64'(wr_data), 64'd0);
    check_output("midrst_hold_h", 64'(h_cpu_hold), 64'd1);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_output("midrst_wr_count", 64'(got_q.size()), 64'd1);
    check_output("midrst_idle_rdy", 64'(in_ready), 64'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
